// File: rtl/alu_arbiter.sv
`default_nettype none
// alu_arbiter: round-robin front end that lets two requesters share one combinational ALU.
// Optional build macro ALU_ARB_OPCHECK_EN: illegal ALUOp codes skip the ALU and return an error response.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [DATA_W-1:0] req_data1_0,
  input  logic [DATA_W-1:0] req_data2_0,
  input  logic [3:0]        req_op_0,
  input  logic [4:0]        req_shamt_0,
  output logic              rsp_valid_0,
  input  logic              rsp_ready_0,
  output logic [DATA_W-1:0] rsp_result_0,
  output logic              rsp_zero_0,
  output logic              rsp_err_0,

  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [DATA_W-1:0] req_data1_1,
  input  logic [DATA_W-1:0] req_data2_1,
  input  logic [3:0]        req_op_1,
  input  logic [4:0]        req_shamt_1,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_1,
  output logic [DATA_W-1:0] rsp_result_1,
  output logic              rsp_zero_1,
  output logic              rsp_err_1,

  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [3:0]        alu_op,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ptr_q, ptr_d;   // 1: requester 1 wins a tie
  logic              gnt_q, gnt_d;   // requester owning the in-flight operation
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic sel1;
  logic accept;
  logic op_legal;
  logic in_resp;
  logic rsp_hs;

  assign sel1    = req_valid_1 & (~req_valid_0 | ptr_q);
  assign accept  = (state_q == IDLE) & (req_valid_0 | req_valid_1);
  assign in_resp = (state_q == RESP);
  assign rsp_hs  = in_resp & (gnt_q ? rsp_ready_1 : rsp_ready_0);

  assign req_ready_0 = accept & ~sel1;
  assign req_ready_1 = accept & sel1;

`ifdef ALU_ARB_OPCHECK_EN
  assign op_legal = (op_q >= 4'h1) && (op_q <= 4'hA);
`else
  assign op_legal = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d   = sel1;
          opa_d   = sel1 ? req_data1_1 : req_data1_0;
          opb_d   = sel1 ? req_data2_1 : req_data2_0;
          op_d    = sel1 ? req_op_1    : req_op_0;
          shamt_d = sel1 ? req_shamt_1 : req_shamt_0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // An illegal op never reaches the ALU; it completes as a zero result with err set.
        res_d   = op_legal ? alu_result : '0;
        zero_d  = op_legal ? alu_zero : 1'b1;
        err_d   = ~op_legal;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= 4'h0;
      shamt_q <= 5'd0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    alu_data1 = '0;
    alu_data2 = '0;
    alu_op    = 4'b0000;
    alu_shamt = 5'd0;
    if (state_q == EXEC) begin
      alu_data1 = opa_q;
      alu_data2 = opb_q;
      alu_op    = op_legal ? op_q : 4'b0000;
      alu_shamt = shamt_q;
    end
  end

  // Response fields are gated by valid so an idle port always reads as zero.
  assign rsp_valid_0  = in_resp & ~gnt_q;
  assign rsp_valid_1  = in_resp & gnt_q;
  assign rsp_result_0 = rsp_valid_0 ? res_q : '0;
  assign rsp_result_1 = rsp_valid_1 ? res_q : '0;
  assign rsp_zero_0   = rsp_valid_0 & zero_q;
  assign rsp_zero_1   = rsp_valid_1 & zero_q;

`ifdef ALU_ARB_OPCHECK_EN
  assign rsp_err_0 = rsp_valid_0 & err_q;
  assign rsp_err_1 = rsp_valid_1 & err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign rsp_err_0  = 1'b0;
  assign rsp_err_1  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// tb_alu_arbiter: directed vectors with a response scoreboard; a behavioural ALU serves as the shared unit.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SUBU = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_data1_0 = '0, req_data2_0 = '0, req_data1_1 = '0, req_data2_1 = '0;
  logic [3:0]  req_op_0 = '0, req_op_1 = '0;
  logic [4:0]  req_shamt_0 = '0, req_shamt_1 = '0;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0 = 1'b1, rsp_ready_1 = 1'b1;
  logic [31:0] rsp_result_0, rsp_result_1;
  logic        rsp_zero_0, rsp_zero_1, rsp_err_0, rsp_err_1;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic        alu_zero;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_data1_0(req_data1_0), .req_data2_0(req_data2_0),
    .req_op_0(req_op_0), .req_shamt_0(req_shamt_0),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
    .rsp_result_0(rsp_result_0), .rsp_zero_0(rsp_zero_0), .rsp_err_0(rsp_err_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_data1_1(req_data1_1), .req_data2_1(req_data2_1),
    .req_op_1(req_op_1), .req_shamt_1(req_shamt_1),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_result_1(rsp_result_1), .rsp_zero_1(rsp_zero_1), .rsp_err_1(rsp_err_1),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Shared ALU: unknown codes produce 0.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = alu_data1 + alu_data2;
      OP_AND:  alu_result = alu_data1 & alu_data2;
      OP_NOR:  alu_result = ~(alu_data1 | alu_data2);
      OP_OR:   alu_result = alu_data1 | alu_data2;
      OP_SLL:  alu_result = alu_data1 << alu_shamt;
      OP_SRL:  alu_result = alu_data1 >> alu_shamt;
      OP_SLT:  alu_result = {31'd0, $signed(alu_data1) < $signed(alu_data2)};
      OP_SLTU: alu_result = {31'd0, alu_data1 < alu_data2};
      OP_SUB:  alu_result = alu_data1 - alu_data2;
      OP_SUBU: alu_result = alu_data1 - alu_data2;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic rv(input int g);
    return (g == 0) ? rsp_valid_0 : rsp_valid_1;
  endfunction

  function automatic logic rr(input int g);
    return (g == 0) ? req_ready_0 : req_ready_1;
  endfunction

  task automatic push(input int g, input exp_t e);
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic set_req(input int g, input logic v, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [3:0] op, input logic [4:0] sh);
    if (g == 0) begin
      req_valid_0 = v; req_data1_0 = d1; req_data2_0 = d2; req_op_0 = op; req_shamt_0 = sh;
    end else begin
      req_valid_1 = v; req_data1_1 = d1; req_data2_1 = d2; req_op_1 = op; req_shamt_1 = sh;
    end
  endtask

  // Monitor: every cycle a response is presented it must match the head of that port's queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid_0 && rsp_valid_1) chk("both_rsp_valid", 32'd1, 32'd0);
      if (rsp_valid_0) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
        else begin
          chk("rsp0_result", rsp_result_0, q0[0].r);
          chk("rsp0_zero", {31'd0, rsp_zero_0}, {31'd0, q0[0].z});
          chk("rsp0_err", {31'd0, rsp_err_0}, {31'd0, q0[0].e});
          if (rsp_ready_0) void'(q0.pop_front());
        end
      end
      if (rsp_valid_1) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
        else begin
          chk("rsp1_result", rsp_result_1, q1[0].r);
          chk("rsp1_zero", {31'd0, rsp_zero_1}, {31'd0, q1[0].z});
          chk("rsp1_err", {31'd0, rsp_err_1}, {31'd0, q1[0].e});
          if (rsp_ready_1) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic wait_accept(input int g, output logic acc);
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = rr(g);
    end
    chk("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = !rsp_valid_0 && !rsp_valid_1 && q0.size() == 0 && q1.size() == 0;
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  // One operation: acceptance N, EXEC at N+1, response at N+2, valid gone at N+3.
  task automatic do_op(input int g, input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] op,
                       input logic [4:0] sh, input logic [3:0] exp_aluop, input logic [31:0] er,
                       input logic ez, input logic ee);
    logic acc;
    @(posedge clk); #1;
    set_req(g, 1'b1, d1, d2, op, sh);
    wait_accept(g, acc);
    if (acc) push(g, '{r: er, z: ez, e: ee});
    @(posedge clk); #1;
    set_req(g, 1'b0, '0, '0, 4'h0, 5'd0);
    @(negedge clk);
    chk("exec_alu_op", {28'd0, alu_op}, {28'd0, exp_aluop});
    chk("exec_alu_data1", alu_data1, d1);
    chk("exec_alu_shamt", {27'd0, alu_shamt}, {27'd0, sh});
    chk("exec_no_rsp", {31'd0, rv(g)}, 32'd0);
    @(negedge clk);
    chk("lat_rsp_valid", {31'd0, rv(g)}, 32'd1);
    @(negedge clk);
    chk("rsp_dropped", {31'd0, rv(g)}, 32'd0);
    chk("idle_alu_op", {28'd0, alu_op}, 32'd0);
    chk("idle_alu_data", alu_data1 | alu_data2 | {27'd0, alu_shamt}, 32'd0);
    wait_drain();
  endtask

  initial begin
    logic acc;
    int   cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
    chk("rst_rsp_data", rsp_result_0 | rsp_result_1, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_zero_0, rsp_zero_1, rsp_err_0, rsp_err_1}, 32'd0);
    chk("rst_alu", alu_data1 | alu_data2 | {23'd0, alu_op, alu_shamt}, 32'd0);

    // Tie after reset: pointer favours requester 0, requester 1 follows three cycles later.
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h81555FCD, 32'h0003FFF0, OP_AND, 5'd0);
    set_req(1, 1'b1, 32'h81555FCD, 32'h0003FFF0, OP_OR, 5'd0);
    @(negedge clk);
    chk("tie_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("tie_ready1", {31'd0, req_ready_1}, 32'd0);
    push(0, '{r: 32'h00015FC0, z: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0, 4'h0, 5'd0);
    cnt = 0;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      cnt++;
      acc = req_ready_1;
    end
    chk("tie_spacing", cnt, 32'd3);
    if (acc) push(1, '{r: 32'h8157FFFD, z: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    set_req(1, 1'b0, '0, '0, 4'h0, 5'd0);
    wait_drain();

    do_op(0, 32'h81555FCD, 32'h0003FFF0, OP_ADD, 5'd0, OP_ADD, 32'h81595FBD, 1'b0, 1'b0);

    // Response held by back-pressure while requester 0 waits.
    @(posedge clk); #1;
    rsp_ready_1 = 1'b0;
    set_req(1, 1'b1, 32'h81555FCD, 32'h81555FCD, OP_SUB, 5'd0);
    wait_accept(1, acc);
    if (acc) push(1, '{r: 32'h0, z: 1'b1, e: 1'b0});
    @(posedge clk); #1;
    set_req(1, 1'b0, '0, '0, 4'h0, 5'd0);
    set_req(0, 1'b1, 32'd1, 32'd2, OP_ADD, 5'd0);
    @(negedge clk);
    chk("hold_exec_ready0", {31'd0, req_ready_0}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid_1) cnt++;
      chk("hold_no_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready_1 = 1'b1;
    @(negedge clk);
    if (rsp_valid_1) cnt++;
    chk("hold_valid_cycles", cnt, 32'd5);
    @(negedge clk);
    chk("hold_released", {31'd0, rsp_valid_1}, 32'd0);
    chk("hold_next_ready0", {31'd0, req_ready_0}, 32'd1);
    if (req_ready_0) push(0, '{r: 32'd3, z: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0, 4'h0, 5'd0);
    wait_drain();

    do_op(0, 32'h81555FCD, 32'h0, OP_SLL, 5'd2, OP_SLL, 32'h05557F34, 1'b0, 1'b0);
    do_op(1, 32'h81555FCD, 32'h0, OP_SRL, 5'd3, OP_SRL, 32'h102AABF9, 1'b0, 1'b0);
    do_op(0, 32'h81555FCD, 32'h0003FFF0, OP_NOR, 5'd0, OP_NOR, 32'h7EA80002, 1'b0, 1'b0);
    do_op(1, 32'h81555FCD, 32'h0003FFF0, OP_SLT, 5'd0, OP_SLT, 32'h00000001, 1'b0, 1'b0);
    do_op(0, 32'h81555FCD, 32'h0003FFF0, OP_SLTU, 5'd0, OP_SLTU, 32'h0, 1'b1, 1'b0);
    do_op(1, 32'h0003FFF0, 32'h81555FCD, OP_SUBU, 5'd0, OP_SUBU, 32'h7EAEA023, 1'b0, 1'b0);

    // Reset during RESP aborts the operation.
    @(posedge clk); #1;
    rsp_ready_0 = 1'b0;
    set_req(0, 1'b1, 32'h0F0F0000, 32'h000000F0, OP_OR, 5'd0);
    wait_accept(0, acc);
    if (acc) push(0, '{r: 32'h0F0F00F0, z: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0, 4'h0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_resp", {31'd0, rsp_valid_0}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    q0.delete();
    rst_n = 1'b1;
    rsp_ready_0 = 1'b1;
    @(negedge clk);
    chk("abort_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
    chk("abort_rsp_data", rsp_result_0 | {31'd0, rsp_zero_0 | rsp_err_0}, 32'd0);
    chk("abort_req_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
    chk("abort_alu", alu_data1 | alu_data2 | {23'd0, alu_op, alu_shamt}, 32'd0);
    repeat (4) @(negedge clk);

    // Illegal op: blocked with an error when checking is built in, passed through otherwise.
`ifdef ALU_ARB_OPCHECK_EN
    do_op(1, 32'h12345678, 32'h1, 4'b1111, 5'd0, 4'b0000, 32'h0, 1'b1, 1'b1);
`else
    do_op(1, 32'h12345678, 32'h1, 4'b1111, 5'd0, 4'b1111, 32'h0, 1'b1, 1'b0);
`endif
    do_op(0, 32'h81555FCD, 32'h0003FFF0, OP_ADD, 5'd0, OP_ADD, 32'h81595FBD, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; the block SHALL support only 32.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid_0/req_valid_1  input  1 each  requester i has an operation pending.
REQ-005 req_ready_0/req_ready_1  output  1 each  operation of requester i accepted this cycle.
REQ-006 req_data1_i, req_data2_i  input  32 each  operands; req_op_i  input  4  ALUOp; req_shamt_i  input  5  shift amount (i = 0,1).
REQ-007 rsp_valid_i  output  1; rsp_ready_i  input  1; rsp_result_i  output  32; rsp_zero_i  output  1; rsp_err_i  output  1 (i = 0,1).
REQ-008 alu_data1, alu_data2  output  32; alu_op  output  4; alu_shamt  output  5  drive to the shared combinational ALU.
REQ-009 alu_result  input  32; alu_zero  input  1  returned by the shared ALU in the same cycle.

Function
REQ-010 FSM states SHALL be IDLE, EXEC, RESP, encoded in 2 bits.
REQ-011 IDLE: if any req_valid is high, grant exactly one requester, assert its req_ready combinationally that cycle, latch its data1/data2/op/shamt, go to EXEC; otherwise stay in IDLE.
REQ-012 req_ready_i SHALL be high only in IDLE for the granted requester; never in EXEC or RESP.
REQ-013 Both valid in IDLE: grant the requester indicated by the round-robin pointer; only one valid: grant it, regardless of the pointer.
REQ-014 The pointer SHALL toggle to the other requester on the RESP->IDLE transition, so the requester just served gets lowest priority.
REQ-015 EXEC: drive alu_* from the latched operands, register alu_result/alu_zero into the response registers, go to RESP; EXEC SHALL last exactly one cycle.
REQ-016 Outside EXEC, alu_data1/alu_data2/alu_shamt SHALL be 0 and alu_op SHALL be 4'b0000.
REQ-017 RESP: rsp_valid of the granted requester SHALL be high and the other requester's rsp_valid low; result, zero and err SHALL be stable until rsp_ready is high.
REQ-018 RESP with rsp_ready high: go to IDLE and drop rsp_valid the next cycle; with rsp_ready low: stay in RESP.
REQ-019 Latency: acceptance in cycle N -> rsp_valid in cycle N+2; minimum spacing of accepted operations is 3 cycles.
REQ-020 The requester SHALL hold valid and operands until ready; the block SHALL ignore valid deasserted before acceptance.
REQ-021 A request arriving while not IDLE SHALL wait; no queueing beyond the one in-flight operation.
REQ-022 Legal ALUOp codes: 0001 ADD, 0010 AND, 0011 NOR, 0100 OR, 0101 SLL, 0110 SRL, 0111 SLT, 1000 SLTU, 1001 SUB, 1010 SUBU.

Reset
REQ-023 While rst_n is low at a rising edge: state <= IDLE, pointer <= requester 0, and operand/response registers <= 0.
REQ-024 After reset, all req_ready, rsp_valid, rsp_result, rsp_zero and rsp_err outputs SHALL be 0 and alu_* outputs SHALL be 0.
REQ-025 Reset in EXEC or RESP SHALL abort the operation; no response is ever issued for it.

Configuration
REQ-026 Macro ALU_ARB_OPCHECK_EN defined: an op outside REQ-022 SHALL be accepted normally, but in EXEC alu_op stays 0000 and the response is result 0, zero 1, err 1 with the same latency.
REQ-027 Macro ALU_ARB_OPCHECK_EN undefined: the op SHALL pass to alu_op unchecked, and rsp_err_0/rsp_err_1 SHALL be constant 0.

Verification (bench instantiates ALU as the shared unit)
REQ-028 Req0 ADD: 0x81555FCD + 0x0003FFF0, accepted in cycle N -> rsp_valid_0 in cycle N+2, result 0x81595FBD, zero 0, err 0.
REQ-029 Both valid after reset: req0 AND, req1 OR, same operands -> req0 served first (result 0x00015FC0), then req1 (result 0x8157FFFD); each response requires 3 cycles.
REQ-030 Req1 SUB: 0x81555FCD - 0x81555FCD with rsp_ready_1 low for 4 cycles -> rsp_valid_1 held for 5 cycles, result 0, zero 1 stable, no req_ready during the hold.
REQ-031 Req0 SLL: data1 0x81555FCD, shamt 2 -> result 0x05557F34; then req1 SRL with shamt 3 -> result 0x102AABF9.
REQ-032 Reset pulsed while in RESP -> the next cycle shows all outputs 0 and state IDLE; the aborted operation never gets rsp_valid.
REQ-033 With ALU_ARB_OPCHECK_EN defined, op 1111 -> result 0, zero 1, err 1 at N+2 and alu_op stays 0000; with it undefined -> err 0.
